fetch_pc_stage: RTL and testbench
=================================

// Module: fetch_pc_stage
// PURPOSE
//  Instruction-fetch stage: holds the program counter, computes PC+4 (PCAdder) for the
//  PC source mux, and registers the fetched instruction into the IF/ID pipeline register.
//  It consumes the mux's PCSrc output as the next PC. Redirects (branch/jr/jump resolved
//  in EX/MEM) flush IF/ID, and hazard-unit stalls freeze PC and IF/ID.
//  It also tolerates a not-ready instruction memory and counts flushes for debug.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  NOP_INSTR   32'h0000_0000  instruction word injected on bubble/flush (sll $0,$0,0)
//  CNT_W       16             width of saturating flush counter
// PORTS
//  Clk               in   1      clock, all state updates on rising edge
//  Rst               in   1      synchronous, active-high reset
//  PCSrc             in   32     next-PC from PC source mux
//  Redirect          in   1      BranchGate|JrGate|EX_MEM_Jump; PCSrc is a taken target
//  PCWrite           in   1      hazard unit; 0 = hold PC
//  IFIDWrite         in   1      hazard unit; 0 = hold IF/ID register
//  InstrIn           in   32     instruction memory read data for address PC
//  InstrValid        in   1      InstrIn is valid this cycle
//  PC                out  32     current PC, drives instruction memory address
//  PCAdder           out  32     PC + 4, combinational, to PC source mux
//  IF_ID_Instruction out  32     registered instruction
//  IF_ID_PCAdder     out  32     registered PC+4 of that instruction
//  IF_ID_Valid       out  1      1 = IF/ID holds a real instruction
//  FlushCount        out  CNT_W  saturating count of redirect flushes
// BEHAVIOUR
//  Reset (Rst=1 at edge): PC=RESET_PC, IF_ID_Instruction=NOP_INSTR, IF_ID_PCAdder=0,
//   IF_ID_Valid=0, FlushCount=0, state=BOOT. Reset overrides every other input.
//  FSM: BOOT -> RUN after exactly one cycle. In BOOT: PC holds, IF/ID loads bubble,
//   Redirect/PCWrite ignored. RUN is permanent until Rst.
//  PCAdder = PC + 32'd4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), no flags.
//  PC update in RUN, priority order:
//   1) Redirect=1 -> PC<=PCSrc (overrides PCWrite=0 and InstrValid=0)
//   2) PCWrite=0 or InstrValid=0 -> PC holds
//   3) else PC<=PCSrc
//  IF/ID update in RUN, priority order:
//   1) Redirect=1 -> IF_ID_Instruction<=NOP_INSTR, IF_ID_Valid<=0, IF_ID_PCAdder<=0
//      (flush wins over IFIDWrite=0)
//   2) IFIDWrite=0 -> all IF/ID fields hold
//   3) InstrValid=0 -> bubble (NOP_INSTR, Valid 0, PCAdder 0)
//   4) else IF_ID_Instruction<=InstrIn, IF_ID_PCAdder<=PCAdder, IF_ID_Valid<=1
//  Latency: instruction at PC appears on IF/ID one edge after InstrValid=1 with
//   IFIDWrite=1 and Redirect=0. Taken redirect: target PC visible next cycle,
//   one IF bubble.
//  Stall coherence: PCWrite=0 with IFIDWrite=1 is legal; IF/ID re-captures the same
//   instruction.
//  FlushCount: +1 on each RUN-cycle edge with Redirect=1; saturates at all-ones.
//  Reset mid-stall or mid-redirect: reset values apply at that edge, no residue.
//  No combinational path from Redirect/PCSrc to any output except through registers;
//   PCAdder depends only on PC.
// TESTING
//  Reset then free-run, InstrValid=1, PCSrc=PCAdder: BOOT cycle Valid=0; then PC
//   0,4,8,12; IF/ID PCAdder 4,8,12 with matching InstrIn.
//  PCWrite=0, IFIDWrite=0 for 3 cycles at PC=0x10: PC stays 0x10, IF/ID frozen;
//   release -> PC=0x14 next edge.
//  Redirect=1, PCSrc=0x40 while PCWrite=0, IFIDWrite=0: next edge PC=0x40,
//   IF_ID_Valid=0, Instruction=NOP_INSTR, FlushCount+1.
//  InstrValid=0 for 2 cycles at PC=0x20: PC holds 0x20, two bubbles;
//   InstrValid=1 -> IF/ID captures InstrIn, PCAdder=0x24.
//  PC=32'hFFFF_FFFC: PCAdder=0; advance -> PC=0. CNT_W=2 with 5 redirects:
//   FlushCount stops at 3.
//  Rst asserted during a redirect cycle: PC=RESET_PC, FlushCount=0, state BOOT.

Source files
------------

// File: rtl/fetch_pc_stage_if.sv
// Fetch-stage bus: redirect/stall/imem inputs and PC / IF-ID pipeline outputs.
interface fetch_pc_stage_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      PCSrc;
  logic             Redirect;
  logic             PCWrite;
  logic             IFIDWrite;
  logic [31:0]      InstrIn;
  logic             InstrValid;
  logic [31:0]      PC;
  logic [31:0]      PCAdder;
  logic [31:0]      IF_ID_Instruction;
  logic [31:0]      IF_ID_PCAdder;
  logic             IF_ID_Valid;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output PCSrc, Redirect, PCWrite, IFIDWrite, InstrIn, InstrValid,
    input  PC, PCAdder, IF_ID_Instruction, IF_ID_PCAdder, IF_ID_Valid, FlushCount
  );

  modport slave (
    input  PCSrc, Redirect, PCWrite, IFIDWrite, InstrIn, InstrValid,
    output PC, PCAdder, IF_ID_Instruction, IF_ID_PCAdder, IF_ID_Valid, FlushCount
  );
endinterface

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder, IF/ID pipeline register with
// redirect flush, hazard stalls, imem-not-ready bubbles and a saturating flush counter.
module fetch_pc_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input logic                Clk,
  input logic                Rst,
  fetch_pc_stage_if.slave    bus
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [31:0]      pc_r;
  logic [31:0]      pc_nxt_s;
  logic [31:0]      pc_add_s;
  logic [31:0]      ifid_instr_r;
  logic [31:0]      ifid_instr_nxt_s;
  logic [31:0]      ifid_pcadd_r;
  logic [31:0]      ifid_pcadd_nxt_s;
  logic             ifid_valid_r;
  logic             ifid_valid_nxt_s;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] flush_cnt_nxt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  assign pc_add_s = pc_r + 32'd4;

  // Next-state selection: redirect beats stalls, stalls beat imem-not-ready bubbles.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    ifid_instr_nxt_s = ifid_instr_r;
    ifid_pcadd_nxt_s = ifid_pcadd_r;
    ifid_valid_nxt_s = ifid_valid_r;
    flush_cnt_nxt_s  = flush_cnt_r;
    case (state_r)
      BOOT: begin
        state_nxt_s      = RUN;
        ifid_instr_nxt_s = NOP_INSTR;
        ifid_pcadd_nxt_s = 32'h0000_0000;
        ifid_valid_nxt_s = 1'b0;
      end
      RUN: begin
        if (bus.Redirect) begin
          pc_nxt_s = bus.PCSrc;
        end else if (bus.PCWrite && bus.InstrValid) begin
          pc_nxt_s = bus.PCSrc;
        end else begin
          pc_nxt_s = pc_r;
        end

        if (bus.Redirect) begin
          ifid_instr_nxt_s = NOP_INSTR;
          ifid_pcadd_nxt_s = 32'h0000_0000;
          ifid_valid_nxt_s = 1'b0;
          flush_cnt_nxt_s  = sat_inc(flush_cnt_r);
        end else if (!bus.IFIDWrite) begin
          ifid_instr_nxt_s = ifid_instr_r;
          ifid_pcadd_nxt_s = ifid_pcadd_r;
          ifid_valid_nxt_s = ifid_valid_r;
        end else if (!bus.InstrValid) begin
          ifid_instr_nxt_s = NOP_INSTR;
          ifid_pcadd_nxt_s = 32'h0000_0000;
          ifid_valid_nxt_s = 1'b0;
        end else begin
          ifid_instr_nxt_s = bus.InstrIn;
          ifid_pcadd_nxt_s = pc_add_s;
          ifid_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s      = BOOT;
        ifid_instr_nxt_s = NOP_INSTR;
        ifid_pcadd_nxt_s = 32'h0000_0000;
        ifid_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State registers; reset wins over every other input.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC;
      ifid_instr_r <= NOP_INSTR;
      ifid_pcadd_r <= 32'h0000_0000;
      ifid_valid_r <= 1'b0;
      flush_cnt_r  <= '0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      ifid_instr_r <= ifid_instr_nxt_s;
      ifid_pcadd_r <= ifid_pcadd_nxt_s;
      ifid_valid_r <= ifid_valid_nxt_s;
      flush_cnt_r  <= flush_cnt_nxt_s;
    end
  end

  assign bus.PC                = pc_r;
  assign bus.PCAdder           = pc_add_s;
  assign bus.IF_ID_Instruction = ifid_instr_r;
  assign bus.IF_ID_PCAdder     = ifid_pcadd_r;
  assign bus.IF_ID_Valid       = ifid_valid_r;
  assign bus.FlushCount        = flush_cnt_r;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: directed scenarios plus random traffic checked
// against a rule-level fetch model; a CNT_W=2 twin checks counter saturation.
module tb_fetch_pc_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcadd;
    logic [31:0] ins;
    logic [31:0] ifpc;
    logic        valid;
    logic [31:0] cnt16;
    logic [31:0] cnt2;
  } exp_t;

  logic Clk;
  logic Rst;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  // model state
  bit          m_run;
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic [31:0] m_ifpc;
  logic        m_valid;
  int          m_cnt;

  fetch_pc_stage_if #(.CNT_W(16)) bus ();
  fetch_pc_stage_if #(.CNT_W(2))  bus2 ();

  assign bus2.PCSrc      = bus.PCSrc;
  assign bus2.Redirect   = bus.Redirect;
  assign bus2.PCWrite    = bus.PCWrite;
  assign bus2.IFIDWrite  = bus.IFIDWrite;
  assign bus2.InstrIn    = bus.InstrIn;
  assign bus2.InstrValid = bus.InstrValid;

  fetch_pc_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .bus(bus)
  );
  fetch_pc_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Rst(Rst), .bus(bus2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, queue expectation.
  task automatic step(input logic rst, input logic red, input logic pcw, input logic ifw,
                      input logic iv, input logic [31:0] src, input logic [31:0] ins);
    exp_t e;
    @(negedge Clk);
    Rst = rst;
    bus.Redirect = red;
    bus.PCWrite = pcw;
    bus.IFIDWrite = ifw;
    bus.InstrValid = iv;
    bus.PCSrc = src;
    bus.InstrIn = ins;
    if (rst) begin
      m_run = 1'b0; m_pc = RESET_PC; m_ins = NOP_INSTR; m_ifpc = 32'h0; m_valid = 1'b0;
      m_cnt = 0;
    end else if (!m_run) begin
      m_run = 1'b1; m_ins = NOP_INSTR; m_ifpc = 32'h0; m_valid = 1'b0;
    end else begin
      logic [31:0] old_pc;
      old_pc = m_pc;
      if (red || (pcw && iv)) m_pc = src;
      if (red) begin
        m_ins = NOP_INSTR; m_ifpc = 32'h0; m_valid = 1'b0; m_cnt = m_cnt + 1;
      end else if (ifw) begin
        if (iv) begin
          m_ins = ins; m_ifpc = old_pc + 32'd4; m_valid = 1'b1;
        end else begin
          m_ins = NOP_INSTR; m_ifpc = 32'h0; m_valid = 1'b0;
        end
      end
    end
    e.pc = m_pc;
    e.pcadd = m_pc + 32'd4;
    e.ins = m_ins;
    e.ifpc = m_ifpc;
    e.valid = m_valid;
    e.cnt16 = (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt);
    e.cnt2 = (m_cnt > 3) ? 32'd3 : 32'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, m_pc + 32'd4, $urandom);
  endtask

  // Monitor: compare DUT outputs just after each edge against the queued expectation.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc", bus.PC, e.pc);
      chk("pcadder", bus.PCAdder, e.pcadd);
      chk("ifid_instr", bus.IF_ID_Instruction, e.ins);
      chk("ifid_pcadder", bus.IF_ID_PCAdder, e.ifpc);
      chk("ifid_valid", {31'b0, bus.IF_ID_Valid}, {31'b0, e.valid});
      chk("flushcount", {16'b0, bus.FlushCount}, e.cnt16);
      chk("flushcount_sat2", {30'b0, bus2.FlushCount}, e.cnt2);
    end
  end

  initial begin
    logic r, red, pcw, ifw, iv;
    logic [31:0] src;
    n_chk = 0; n_fail = 0;
    m_run = 1'b0; m_pc = RESET_PC; m_ins = NOP_INSTR; m_ifpc = 32'h0; m_valid = 1'b0;
    m_cnt = 0;
    Rst = 1'b1;
    bus.Redirect = 1'b0; bus.PCWrite = 1'b1; bus.IFIDWrite = 1'b1; bus.InstrValid = 1'b1;
    bus.PCSrc = 32'h0; bus.InstrIn = 32'h0;

    // reset, boot bubble, free run 0,4,8,... until PC=0x10
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 8 && m_pc != 32'h10; i++) run(1);

    // full stall for three cycles, then release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_pc + 32'd4, $urandom);
    run(1);

    // redirect during full stall
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, $urandom);
    run(2);

    // imem not ready at PC=0x20
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h20, $urandom);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h24, $urandom);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h24, $urandom);
    run(2);

    // PC+4 wrap
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, $urandom);
    run(3);

    // PCWrite=0 with IFIDWrite=1 re-captures the same slot
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, m_pc + 32'd4, 32'hCAFE_0001);
    run(1);

    // redirect burst drives the 2-bit counter into saturation
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, $urandom & 32'hFFFF_FFFC, $urandom);
    run(1);

    // reset asserted in a redirect cycle, then recovery
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, $urandom);
    run(3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      red = ($urandom_range(0, 5) == 0);
      pcw = ($urandom_range(0, 4) != 0);
      ifw = ($urandom_range(0, 4) != 0);
      iv  = ($urandom_range(0, 3) != 0);
      src = ($urandom_range(0, 1) == 0) ? (m_pc + 32'd4) : ($urandom & 32'hFFFF_FFFC);
      step(r, red, pcw, ifw, iv, src, $urandom);
    end

    @(posedge Clk);
    @(posedge Clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
